// File: rtl/me_stage_pkg.sv
// Shared types and constants for the memory-access stage: EX->ME and ME->WB
// bus layouts plus the dest_flag field positions used by the load aligner.
package me_stage_pkg;

  localparam int EX_ME_W = 76;
  localparam int ME_WB_W = 70;
  localparam int DATA_W  = 32;
  localparam int DEST_W  = 5;

  // dest_flag = {src_is_signed, mem_is_byte, mem_is_half, offset[1:0]}
  localparam int FLAG_W      = 5;
  localparam int FLAG_SIGNED = 4;
  localparam int FLAG_BYTE   = 3;
  localparam int FLAG_HALF   = 2;
  localparam int FLAG_OFF_HI = 1;
  localparam int FLAG_OFF_LO = 0;

  typedef enum logic [1:0] {
    LD_WORD,
    LD_HALF,
    LD_BYTE
  } load_size_e;

  typedef struct packed {
    logic [FLAG_W-1:0] dest_flag;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_result;
    logic              res_from_mem;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
  } ex_me_bus_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] final_result;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
  } me_wb_bus_t;

endpackage

// File: rtl/me_load_align.sv
// Combinational load extractor: picks the byte/half/word addressed by the
// offset in dest_flag and sign- or zero-extends it. Byte wins over half.
module me_load_align
  import me_stage_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [FLAG_W-1:0] dest_flag,
  output logic [DATA_W-1:0] load_data
);

  load_size_e size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  always_comb begin
    size = LD_WORD;
    if (dest_flag[FLAG_BYTE])
      size = LD_BYTE;
    else if (dest_flag[FLAG_HALF])
      size = LD_HALF;
  end

  always_comb begin
    byte_sel  = rdata[7:0];
    half_sel  = rdata[15:0];
    sign_en   = dest_flag[FLAG_SIGNED];
    load_data = rdata;

    case (dest_flag[FLAG_OFF_HI:FLAG_OFF_LO])
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase

    // offset[0] is meaningless for halfword accesses
    if (dest_flag[FLAG_OFF_HI])
      half_sel = rdata[31:16];

    case (size)
      LD_BYTE: load_data = {{(DATA_W-8){sign_en & byte_sel[7]}}, byte_sel};
      LD_HALF: load_data = {{(DATA_W-16){sign_en & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/me_stage.sv
// Memory-access pipeline stage: one-entry EX->ME register, SRAM read-data
// capture, load alignment and ME->WB / forwarding outputs. Macro ME_PERF_CNT_EN.
module me_stage
  import me_stage_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               EX_to_ME_Valid,
  input  logic [EX_ME_W-1:0] EX_to_ME_Bus,
  output logic               ME_Allow_in,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  input  logic               WB_Allow_in,
  output logic               ME_to_WB_Valid,
  output logic [ME_WB_W-1:0] ME_to_WB_Bus,
  output logic [DEST_W-1:0]  ME_dest,
  output logic [DATA_W-1:0]  ME_Forward_Res
`ifdef ME_PERF_CNT_EN
  ,
  output logic [31:0]        ME_load_cnt,
  output logic [31:0]        ME_stall_cnt
`endif
);

  logic              me_valid;
  logic              first_cycle;
  logic              accept;
  ex_me_bus_t        bus_r;
  me_wb_bus_t        wb_bus;
  logic [DATA_W-1:0] rdata_hold;
  logic [DATA_W-1:0] rdata_eff;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  assign ME_Allow_in = !me_valid || WB_Allow_in;
  assign accept      = ME_Allow_in && EX_to_ME_Valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid    <= 1'b0;
      first_cycle <= 1'b0;
    end else begin
      if (ME_Allow_in)
        me_valid <= EX_to_ME_Valid;
      first_cycle <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      bus_r <= ex_me_bus_t'(EX_to_ME_Bus);
  end

  // EX keeps the SRAM enabled, so its output drifts during a stall; freeze
  // the value seen in the first cycle of residency.
  always_ff @(posedge clk) begin
    if (first_cycle)
      rdata_hold <= data_sram_rdata;
  end

  assign rdata_eff = first_cycle ? data_sram_rdata : rdata_hold;

  me_load_align u_load_align (
    .rdata     (rdata_eff),
    .dest_flag (bus_r.dest_flag),
    .load_data (load_data)
  );

  assign final_result = bus_r.res_from_mem ? load_data : bus_r.alu_result;

  always_comb begin
    wb_bus.pc           = bus_r.pc;
    wb_bus.final_result = final_result;
    wb_bus.gr_we        = bus_r.gr_we;
    wb_bus.dest         = bus_r.dest;
  end

  assign ME_to_WB_Valid = me_valid;
  assign ME_to_WB_Bus   = wb_bus;
  assign ME_dest        = bus_r.dest & {DEST_W{me_valid & bus_r.gr_we}};
  assign ME_Forward_Res = final_result;

`ifdef ME_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ME_load_cnt  <= '0;
      ME_stall_cnt <= '0;
    end else begin
      if (me_valid && WB_Allow_in && bus_r.res_from_mem)
        ME_load_cnt <= ME_load_cnt + 32'd1;
      if (me_valid && !WB_Allow_in)
        ME_stall_cnt <= ME_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
